// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB colour sequencer: colour word,
// fixed 7-entry palette, sequencer states and palette index helpers.
package rgb_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int PALETTE_LEN = 7;

  localparam rgb_t PALETTE [PALETTE_LEN] = '{
    24'h9400D3, 24'h4B0082, 24'h0000FF, 24'h00FF00,
    24'hFFFF00, 24'hFF7F00, 24'hFA1010
  };

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    FADE
  } seq_state_t;

  // Out-of-range indices cannot occur in operation; they read as black.
  function automatic rgb_t palette_at(input logic [2:0] i);
    rgb_t c;
    c = '0;
    if (i < 3'(PALETTE_LEN)) c = PALETTE[i];
    return c;
  endfunction

  function automatic logic [2:0] idx_next(input logic [2:0] i);
    return (i == 3'(PALETTE_LEN - 1)) ? 3'd0 : i + 3'd1;
  endfunction

  function automatic logic [2:0] idx_prev(input logic [2:0] i);
    return (i == 3'd0) ? 3'(PALETTE_LEN - 1) : i - 3'd1;
  endfunction

endpackage

// File: rtl/rgb_lerp.sv
// Combinational 3-channel crossfade: out = (from*(256-k) + to*k) >> 8 per
// channel, with k in 0..256 so k=256 yields the target exactly.
module rgb_lerp
  import rgb_pkg::*;
(
  input  rgb_t       from,
  input  rgb_t       to,
  input  logic [8:0] k,
  output rgb_t       color
);

  function automatic logic [7:0] mix(input logic [7:0] a, input logic [7:0] b,
                                     input logic [8:0] w);
    logic [16:0] acc;
    acc = 17'(a) * 17'(9'd256 - w) + 17'(b) * 17'(w);
    return 8'(acc >> 8);
  endfunction

  always_comb begin
    color.r = mix(from.r, to.r, k);
    color.g = mix(from.g, to.g, k);
    color.b = mix(from.b, to.b, k);
  end

endmodule

// File: rtl/rgb_color_sequencer.sv
// Palette sequencer feeding rgb_led: dwell, optional crossfade, manual steps
// and a req/gnt colour override. Crossfade is built only with RGB_SEQ_FADE_EN.
module rgb_color_sequencer
  import rgb_pkg::*;
#(
  parameter int DWELL_CYCLES = 25_000_000,
  parameter int FADE_TICK    = 97_656
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        enable,
  input  logic        step_up,
  input  logic        step_dn,
  input  logic        ovr_req,
  input  logic [23:0] ovr_color,
  output logic        ovr_gnt,
  output logic [23:0] color,
  output logic [2:0]  index,
  output logic        busy
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  seq_state_t    state, state_d;
  logic [CW-1:0] dwell_cnt, dwell_cnt_d;
  logic [2:0]    index_d, step_idx;
  logic          step, busy_d;
  logic [8:0]    mix_k;
  rgb_t          from_color, to_color, mix_color, seq_color, color_d;

`ifdef RGB_SEQ_FADE_EN
  localparam int TW = (FADE_TICK > 1) ? $clog2(FADE_TICK) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(FADE_TICK - 1);

  logic [8:0]    fade_k, fade_k_d;
  logic [TW-1:0] tick_cnt, tick_cnt_d;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!RST_N) begin
      state     <= IDLE;
      index     <= 3'(PALETTE_LEN - 1);
      dwell_cnt <= '0;
      color     <= '0;
      ovr_gnt   <= 1'b0;
      busy      <= 1'b0;
`ifdef RGB_SEQ_FADE_EN
      fade_k    <= '0;
      tick_cnt  <= '0;
`endif
    end else begin
      state     <= state_d;
      index     <= index_d;
      dwell_cnt <= dwell_cnt_d;
      color     <= color_d;
      ovr_gnt   <= ovr_req;
      busy      <= busy_d;
`ifdef RGB_SEQ_FADE_EN
      fade_k    <= fade_k_d;
      tick_cnt  <= tick_cnt_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d     = state;
    index_d     = index;
    dwell_cnt_d = dwell_cnt;
    step        = step_up ^ step_dn;
    step_idx    = step_up ? idx_next(index) : idx_prev(index);
`ifdef RGB_SEQ_FADE_EN
    fade_k_d    = fade_k;
    tick_cnt_d  = tick_cnt;
`endif
    // A granted override freezes everything; a step beats dwell expiry.
    if (!ovr_req) begin
      if (step) begin
        state_d     = DWELL;
        index_d     = step_idx;
        dwell_cnt_d = '0;
`ifdef RGB_SEQ_FADE_EN
        fade_k_d    = '0;
        tick_cnt_d  = '0;
`endif
      end else if (enable) begin
        case (state)
          IDLE: begin
            state_d     = DWELL;
            index_d     = 3'd0;
            dwell_cnt_d = '0;
          end
          DWELL: begin
            if (dwell_cnt == DWELL_LAST) begin
              dwell_cnt_d = '0;
`ifdef RGB_SEQ_FADE_EN
              state_d     = FADE;
`else
              index_d     = idx_next(index);
`endif
            end else begin
              dwell_cnt_d = dwell_cnt + CW'(1);
            end
          end
`ifdef RGB_SEQ_FADE_EN
          FADE: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt_d = '0;
              // Step 256 lands exactly on the target, so the fade ends there.
              if (fade_k == 9'd255) begin
                state_d  = DWELL;
                index_d  = idx_next(index);
                fade_k_d = '0;
              end else begin
                fade_k_d = fade_k + 9'd1;
              end
            end else begin
              tick_cnt_d = tick_cnt + TW'(1);
            end
          end
`endif
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign from_color = palette_at(index_d);
  assign to_color   = palette_at(idx_next(index_d));

  always_comb begin
    mix_k = '0;
`ifdef RGB_SEQ_FADE_EN
    if (state_d == FADE) mix_k = fade_k_d;
`endif
  end

  rgb_lerp u_lerp (
    .from  (from_color),
    .to    (to_color),
    .k     (mix_k),
    .color (mix_color)
  );

  always_comb begin
    seq_color = mix_color;
    if (state_d == IDLE) seq_color = '0;
    color_d = ovr_req ? rgb_t'(ovr_color) : seq_color;
    busy_d  = (state_d == FADE);
  end

endmodule

// File: tb/tb_rgb_color_sequencer.sv
// Self-checking bench for rgb_color_sequencer: directed scenarios with literal
// expectations plus randomized stimulus against an elapsed-time reference model.
module tb_rgb_color_sequencer;

  localparam int DWELL = 10;
  localparam int TICK  = 1;
`ifdef RGB_SEQ_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        enable = 1'b0, step_up = 1'b0, step_dn = 1'b0, ovr_req = 1'b0;
  logic [23:0] ovr_color = '0;
  logic        ovr_gnt, busy;
  logic [23:0] color;
  logic [2:0]  index;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_on   = 1'b0;

  always #5 CLK = ~CLK;

  rgb_color_sequencer #(.DWELL_CYCLES(DWELL), .FADE_TICK(TICK)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .enable    (enable),
    .step_up   (step_up),
    .step_dn   (step_dn),
    .ovr_req   (ovr_req),
    .ovr_color (ovr_color),
    .ovr_gnt   (ovr_gnt),
    .color     (color),
    .index     (index),
    .busy      (busy)
  );

  // Reference model: tracks elapsed enabled cycles in the current entry/fade.
  logic [23:0] pal [7] = '{24'h9400D3, 24'h4B0082, 24'h0000FF, 24'h00FF00,
                           24'hFFFF00, 24'hFF7F00, 24'hFA1010};
  bit          m_started = 1'b0;
  int          m_idx     = 6;
  int          m_dwell   = 0;
  int          m_fade    = -1;
  logic [23:0] m_color   = '0;
  bit          m_gnt     = 1'b0;

  function automatic logic [23:0] blend(input logic [23:0] a, input logic [23:0] b,
                                        input int k);
    logic [23:0] r;
    r = '0;
    for (int s = 0; s < 24; s += 8) begin
      int ca, cb;
      ca = int'((a >> s) & 24'hFF);
      cb = int'((b >> s) & 24'hFF);
      r  = r | (24'((ca * (256 - k) + cb * k) / 256) << s);
    end
    return r;
  endfunction

  function automatic logic [23:0] model_seq();
    if (!m_started) return 24'h0;
    if (m_fade >= 0) return blend(pal[m_idx], pal[(m_idx + 1) % 7], m_fade / TICK);
    return pal[m_idx];
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_started = 1'b0; m_idx = 6; m_dwell = 0; m_fade = -1;
      m_color = '0; m_gnt = 1'b0;
    end else begin
      m_gnt = ovr_req;
      if (!ovr_req) begin
        if (step_up != step_dn) begin
          m_started = 1'b1;
          m_idx     = (m_idx + (step_up ? 1 : 6)) % 7;
          m_dwell   = 0;
          m_fade    = -1;
        end else if (enable) begin
          if (!m_started) begin
            m_started = 1'b1; m_idx = 0; m_dwell = 0;
          end else if (m_fade < 0) begin
            m_dwell++;
            if (m_dwell == DWELL) begin
              m_dwell = 0;
              if (FADE_EN) m_fade = 0;
              else m_idx = (m_idx + 1) % 7;
            end
          end else begin
            m_fade++;
            if (m_fade == 256 * TICK) begin
              m_fade = -1;
              m_idx  = (m_idx + 1) % 7;
            end
          end
        end
      end
      m_color = ovr_req ? ovr_color : model_seq();
    end
  end

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check4(input string tag, input logic [23:0] c, input logic [2:0] i,
                        input logic b);
    check({tag, ".color"}, color, c);
    check({tag, ".index"}, 24'(index), 24'(i));
    check({tag, ".busy"}, 24'(busy), 24'(b));
  endtask

  always @(negedge CLK) begin
    if (cmp_on) begin
      check("model.color", color, m_color);
      check("model.index", 24'(index), 24'(m_idx));
      check("model.busy", 24'(busy), 24'(m_fade >= 0));
      check("model.ovr_gnt", 24'(ovr_gnt), 24'(m_gnt));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int r;
    tick(3);
    check4("reset", 24'h000000, 3'd6, 1'b0);
    check("reset.ovr_gnt", 24'(ovr_gnt), 24'd0);
    RST_N  = 1'b1;
    cmp_on = 1'b1;

    // First cut to entry 0, then the first transition to entry 1.
    enable = 1'b1;
    tick(1);
    check4("start", 24'h9400D3, 3'd0, 1'b0);
`ifdef RGB_SEQ_FADE_EN
    tick(DWELL);
    check4("fade_start", 24'h9400D3, 3'd0, 1'b1);
    tick(128);
    check4("fade_mid", 24'h6F00AA, 3'd0, 1'b1);
    tick(128);
    check4("fade_end", 24'h4B0082, 3'd1, 1'b0);
`else
    tick(DWELL);
    check4("cut_1", 24'h4B0082, 3'd1, 1'b0);
`endif

    step_up = 1'b1; tick(1); step_up = 1'b0;
    check4("step_up", 24'h0000FF, 3'd2, 1'b0);
`ifdef RGB_SEQ_FADE_EN
    tick(DWELL + 128);
    check4("fade_mid2", 24'h007F7F, 3'd2, 1'b1);
`else
    tick(3);
`endif
    step_dn = 1'b1; tick(1); step_dn = 1'b0;
    check4("step_dn", 24'h4B0082, 3'd1, 1'b0);

    // Simultaneous pulses are ignored and do not clear the dwell count.
    step_up = 1'b1; step_dn = 1'b1; tick(1); step_up = 1'b0; step_dn = 1'b0;
    check4("both_steps", 24'h4B0082, 3'd1, 1'b0);
    tick(DWELL - 2);
    check4("dwell_last", 24'h4B0082, 3'd1, 1'b0);
    tick(1);
`ifdef RGB_SEQ_FADE_EN
    check4("dwell_expire", 24'h4B0082, 3'd1, 1'b1);
    tick(50);
`else
    check4("dwell_expire", 24'h0000FF, 3'd2, 1'b0);
    tick(5);
`endif

    // Override wins over a same-cycle step and freezes the sequencer.
    ovr_color = 24'h123456; ovr_req = 1'b1; step_up = 1'b1; tick(1); step_up = 1'b0;
    check("ovr_on.color", color, 24'h123456);
    check("ovr_on.gnt", 24'(ovr_gnt), 24'd1);
    tick(20);
    check("ovr_hold.color", color, 24'h123456);
    ovr_req = 1'b0; tick(1);
    check("ovr_off.gnt", 24'(ovr_gnt), 24'd0);
`ifdef RGB_SEQ_FADE_EN
    check4("ovr_resume", 24'h3C009A, 3'd1, 1'b1);
    tick(204);
    check4("resume_busy", blend(24'h4B0082, 24'h0000FF, 255), 3'd1, 1'b1);
    tick(1);
    check4("resume_end", 24'h0000FF, 3'd2, 1'b0);
`endif

    // Walk down to entry 6 and verify the wrap back to entry 0.
    for (int n = 0; n < 7 && m_idx != 6; n++) begin
      step_dn = 1'b1; tick(1); step_dn = 1'b0;
    end
    check4("at_6", 24'hFA1010, 3'd6, 1'b0);
    tick(DWELL);
`ifdef RGB_SEQ_FADE_EN
    check4("wrap_fade", 24'hFA1010, 3'd6, 1'b1);
    tick(256);
`endif
    check4("wrap", 24'h9400D3, 3'd0, 1'b0);

    enable = 1'b0; tick(3 * DWELL);
    check4("enable_hold", 24'h9400D3, 3'd0, 1'b0);
    enable = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(0, 299));
      step_up   = (r == 0) || (r == 2);
      step_dn   = (r == 1) || (r == 2);
      enable    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) ovr_req = ~ovr_req;
      ovr_color = 24'($urandom());
      tick(1);
    end
    step_up = 1'b0; step_dn = 1'b0; enable = 1'b1;

    // Asynchronous reset in the middle of a granted override.
    ovr_req = 1'b1; ovr_color = 24'hABCDEF; tick(3);
    check("pre_rst.gnt", 24'(ovr_gnt), 24'd1);
    #2 RST_N = 1'b0;
    #1;
    check4("async_rst", 24'h000000, 3'd6, 1'b0);
    check("async_rst.gnt", 24'(ovr_gnt), 24'd0);
    tick(2);
    ovr_req = 1'b0; enable = 1'b0; RST_N = 1'b1;
    tick(1);

    // A step in IDLE enters DWELL even with enable low.
    step_dn = 1'b1; tick(1); step_dn = 1'b0;
    check4("idle_step", 24'hFF7F00, 3'd5, 1'b0);
    tick(DWELL + 3);
    check4("idle_step_hold", 24'hFF7F00, 3'd5, 1'b0);

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
